// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op encodings, state codes and constants for the divider unit
package div_unit_pkg;

    // ALU operation encodings shared with the decoder and scheduler.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;

    // Divider FSM state codes.
    typedef logic [1:0] div_state_t;
    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_BUSY = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;
    localparam div_state_t ST_DONE = 2'd3;

    // One restoring iteration per quotient bit.
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division iteration
//
// Ports:
//   rem      in  W   partial remainder before the shift (always < divisor)
//   dvd_msb  in  1   dividend bit shifted into the remainder this step
//   divisor  in  W   divisor
//   rem_next out W   partial remainder after the conditional subtract
//   q_bit    out 1   quotient bit produced by this step
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dvd_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    // The shifted remainder needs one extra bit: 2*rem+1 can exceed W bits
    // for large unsigned divisors.
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem, dvd_msb};
        diff    = shifted - {1'b0, divisor};
        // Because rem < divisor on entry, diff[W] is set exactly when the
        // subtraction borrows, i.e. when shifted < divisor.
        q_bit    = ~diff[W];
        rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider (DIV signed quotient, REMU unsigned remainder)
//
// Optional feature macro: DIV_ZERO_FASTPATH_EN (divide-by-zero skips the iterations).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   valid_in          scheduler issues an op this cycle
//   ALU_op            operation code (only ALU_DIV / ALU_REMU accepted)
//   rs1, rs2          dividend, divisor
//   ROB_entry         destination ROB tag
//   flush             squash any in-flight op
//   cdb_grant         CDB arbiter takes the presented result
//   ready             unit idle and able to accept
//   result_valid      result presented to the CDB arbiter
//   result            quotient (DIV) or remainder (REMU)
//   result_ROB_entry  tag of the presented result
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       ALU_op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [ROB_W-1:0] ROB_entry,
    input  logic             flush,
    input  logic             cdb_grant,
    output logic             ready,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic [ROB_W-1:0] result_ROB_entry
);

    localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_ITERS - 1);

    div_state_t             state;
    logic [DIV_CNT_W-1:0]   count;
    logic [XLEN-1:0]        rem;
    logic [XLEN-1:0]        dvd;      // dividend shifts out of the top, quotient shifts in at the bottom
    logic [XLEN-1:0]        dvs;
    logic [ROB_W-1:0]       tag_q;
    logic                   is_div;
    logic                   neg_q;
    logic                   div_zero;

    logic                   accept;
    logic                   op_is_div;
    logic [XLEN-1:0]        rs1_mag;
    logic [XLEN-1:0]        rs2_mag;
    logic [XLEN-1:0]        step_rem;
    logic                   step_q;

    always_comb begin
        op_is_div = (ALU_op == ALU_DIV);
        accept    = valid_in && (op_is_div || (ALU_op == ALU_REMU));
        rs1_mag   = rs1[XLEN-1] ? -rs1 : rs1;
        rs2_mag   = rs2[XLEN-1] ? -rs2 : rs2;
    end

    div_step #(.W(XLEN)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .divisor  (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            count            <= '0;
            rem              <= '0;
            dvd              <= '0;
            dvs              <= '0;
            tag_q            <= '0;
            is_div           <= 1'b0;
            neg_q            <= 1'b0;
            div_zero         <= 1'b0;
            result           <= '0;
            result_ROB_entry <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tag_q    <= ROB_entry;
                        is_div   <= op_is_div;
                        dvd      <= op_is_div ? rs1_mag : rs1;
                        dvs      <= op_is_div ? rs2_mag : rs2;
                        neg_q    <= op_is_div && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        div_zero <= (rs2 == '0);
                        rem      <= '0;
                        count    <= CNT_LOAD;
                        state    <= ST_BUSY;
`ifdef DIV_ZERO_FASTPATH_EN
                        // Dividing by zero leaves the dividend as remainder,
                        // so preload it and skip the iterations.
                        if (rs2 == '0) begin
                            rem   <= rs1;
                            state <= ST_FIX;
                        end
`endif
                    end
                end
                ST_BUSY: begin
                    rem <= step_rem;
                    dvd <= {dvd[XLEN-2:0], step_q};
                    if (count == '0) begin
                        state <= ST_FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_FIX: begin
                    // INT_MIN / -1 needs no special case: the magnitude
                    // quotient 0x80000000 negates to itself.
                    if (!is_div) begin
                        result <= rem;
                    end else if (div_zero) begin
                        result <= '1;
                    end else begin
                        result <= neg_q ? -dvd : dvd;
                    end
                    result_ROB_entry <= tag_q;
                    state            <= ST_DONE;
                end
                default: begin
                    if (cdb_grant) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready        = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [3:0]  ALU_op = 4'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [3:0]  ROB_entry = '0;
    logic        flush = 1'b0;
    logic        cdb_grant = 1'b0;
    logic        ready;
    logic        result_valid;
    logic [31:0] result;
    logic [3:0]  result_ROB_entry;

    int total = 0;
    int bad = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 33;
`endif
    localparam int LAT_FULL = 33;

    div_unit #(.XLEN(32), .ROB_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .ALU_op           (ALU_op),
        .rs1              (rs1),
        .rs2              (rs2),
        .ROB_entry        (ROB_entry),
        .flush            (flush),
        .cdb_grant        (cdb_grant),
        .ready            (ready),
        .result_valid     (result_valid),
        .result           (result),
        .result_ROB_entry (result_ROB_entry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op for a single clock edge; returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag);
        @(negedge clk);
        valid_in  = 1'b1;
        ALU_op    = op;
        rs1       = a;
        rs2       = b;
        ROB_entry = tag;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Counts edges after the accepting edge until result_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic grant_and_check(input string name);
        cdb_grant = 1'b1;
        @(negedge clk);
        cdb_grant = 1'b0;
        check({name, "_ready_after_grant"}, {31'd0, ready}, 32'd1);
        check({name, "_valid_after_grant"}, {31'd0, result_valid}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, tag);
        check({name, "_ready_busy"}, {31'd0, ready}, 32'd0);
        wait_result(lat);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, result, exp);
        check({name, "_tag"}, {28'd0, result_ROB_entry}, {28'd0, tag});
        grant_and_check(name);
    endtask

    initial begin
        int lat;
        logic seen;

        // Reset state while reset is held
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag", {28'd0, result_ROB_entry}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Functional vectors
        run_op("remu_100_7",   ALU_REMU, 32'd100,      32'd7,          4'd5,  32'd2,          LAT_FULL);
        run_op("div_m100_7",   ALU_DIV,  32'hFFFFFF9C, 32'd7,          4'd1,  32'hFFFFFFF2,   LAT_FULL);
        run_op("div_min_m1",   ALU_DIV,  32'h80000000, 32'hFFFFFFFF,   4'd2,  32'h80000000,   LAT_FULL);
        run_op("div_7_m2",     ALU_DIV,  32'd7,        32'hFFFFFFFE,   4'd3,  32'hFFFFFFFD,   LAT_FULL);
        run_op("div_5_0",      ALU_DIV,  32'd5,        32'd0,          4'd4,  32'hFFFFFFFF,   LAT_ZERO);
        run_op("div_m5_0",     ALU_DIV,  32'hFFFFFFFB, 32'd0,          4'd6,  32'hFFFFFFFF,   LAT_ZERO);
        run_op("remu_5_0",     ALU_REMU, 32'd5,        32'd0,          4'd7,  32'd5,          LAT_ZERO);
        run_op("remu_big",     ALU_REMU, 32'hFFFFFFFF, 32'hFFFFFFFE,   4'd8,  32'd1,          LAT_FULL);

        // Backpressure: result and tag held while the grant is withheld
        issue(ALU_DIV, 32'd100, 32'd7, 4'd9);
        wait_result(lat);
        check("bp_latency", lat, LAT_FULL);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, result_valid}, 32'd1);
            check("bp_result", result, 32'd14);
            check("bp_tag", {28'd0, result_ROB_entry}, 32'd9);
            check("bp_ready", {31'd0, ready}, 32'd0);
        end
        grant_and_check("bp");

        // Flush mid-iteration
        issue(ALU_DIV, 32'd1000, 32'd3, 4'd10);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {31'd0, ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("flush_no_valid", {31'd0, seen}, 32'd0);

        // Flush together with valid_in in IDLE
        @(negedge clk);
        valid_in = 1'b1; ALU_op = ALU_DIV; rs1 = 32'd9; rs2 = 32'd3; ROB_entry = 4'd11;
        flush = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        flush = 1'b0;
        check("flushvalid_ready", {31'd0, ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("flushvalid_no_valid", {31'd0, seen}, 32'd0);

        // Illegal op ignored, stray grant in IDLE has no effect
        @(negedge clk);
        valid_in = 1'b1; ALU_op = ALU_MUL; rs1 = 32'd9; rs2 = 32'd3; ROB_entry = 4'd12;
        cdb_grant = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        cdb_grant = 1'b0;
        check("mul_ready", {31'd0, ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || !ready) seen = 1'b1;
        end
        check("mul_ignored", {31'd0, seen}, 32'd0);

        // Asynchronous reset during BUSY (last result 14/tag 9 is still held)
        issue(ALU_REMU, 32'd77, 32'd10, 4'd13);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("amid_ready", {31'd0, ready}, 32'd1);
        check("amid_valid", {31'd0, result_valid}, 32'd0);
        check("amid_result", result, 32'd0);
        check("amid_tag", {28'd0, result_ROB_entry}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Unit works normally after reset
        run_op("post_rst", ALU_REMU, 32'd77, 32'd10, 4'd14, 32'd7, LAT_FULL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
